// File: rtl/csr_machine.sv
// Machine-mode CSR file for the single-hart RV32I core: trap entry/exit, prioritised interrupts, 64-bit counters.
// rdata/illegal/trap/trap_pc are combinational from the current state; all updates land on the next clk edge.
module csr_machine #(
  parameter int          NUM_LOCAL_IRQ = 4,
  parameter bit          VECTORED      = 1'b1,
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter bit          HAS_COUNTERS  = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     csr_en,
  input  logic [11:0]              number,
  input  logic [1:0]               access_type,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     illegal,
  input  logic                     external_irq,
  input  logic                     timer_irq,
  input  logic                     software_irq,
  input  logic [NUM_LOCAL_IRQ-1:0] local_irq,
  input  logic                     exception,
  input  logic [3:0]               exception_cause,
  input  logic [31:0]              exception_tval,
  input  logic [31:0]              current_pc,
  input  logic                     instret,
  input  logic                     mret,
  output logic                     trap,
  output logic [31:0]              trap_pc,
  output logic [31:0]              mepc_out
);

  // access_type encoding shared with the decoder
  localparam logic [1:0] CSR_READ_ONLY = 2'd0;
  localparam logic [1:0] CSR_WRITE     = 2'd1;
  localparam logic [1:0] CSR_SET       = 2'd2;
  localparam logic [1:0] CSR_CLEAR     = 2'd3;

  localparam logic [31:0] IRQ_MASK =
    32'h0000_0888 | (((32'h1 << NUM_LOCAL_IRQ) - 32'h1) << 16);

  logic        mstatus_mie, mstatus_mpie;
  logic [31:0] mie_q, mip_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [63:0] mcycle_q, minstret_q;

  logic        implemented, write_en, csr_commit;
  logic [31:0] wval, irq_lines, pending;
  logic        take_irq, is_irq;
  logic [4:0]  irq_code, cause_code;

  always_comb begin
    implemented = 1'b1;
    rdata       = '0;
    case (number)
      12'h301: rdata = 32'h4000_0100;
      12'hF11, 12'hF12, 12'hF13, 12'hF14: rdata = '0;
      12'h300: rdata = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      12'h304: rdata = mie_q;
      12'h344: rdata = mip_q;
      12'h305: rdata = mtvec_q;
      12'h340: rdata = mscratch_q;
      12'h341: rdata = mepc_q;
      12'h342: rdata = mcause_q;
      12'h343: rdata = mtval_q;
      12'hB00: rdata = HAS_COUNTERS ? mcycle_q[31:0]    : 32'h0;
      12'hB80: rdata = HAS_COUNTERS ? mcycle_q[63:32]   : 32'h0;
      12'hB02: rdata = HAS_COUNTERS ? minstret_q[31:0]  : 32'h0;
      12'hB82: rdata = HAS_COUNTERS ? minstret_q[63:32] : 32'h0;
      default: implemented = 1'b0;
    endcase
  end

  assign illegal = csr_en && (!implemented ||
                              (access_type != CSR_READ_ONLY && number[11:10] == 2'b11));
  assign write_en = csr_en && (access_type != CSR_READ_ONLY) && !illegal;

  always_comb begin
    wval = wdata;
    case (access_type)
      CSR_SET:   wval = rdata | wdata;
      CSR_CLEAR: wval = rdata & ~wdata;
      default:   wval = wdata;
    endcase
  end

  always_comb begin
    irq_lines = '0;
    irq_lines[11] = external_irq;
    irq_lines[7]  = timer_irq;
    irq_lines[3]  = software_irq;
    irq_lines[16 +: NUM_LOCAL_IRQ] = local_irq;
  end

  assign pending = mip_q & mie_q;

  // Lowest-priority candidates are assigned first so higher ones overwrite them.
  always_comb begin
    irq_code = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--)
      if (pending[16+i]) irq_code = 5'(16 + i);
    if (pending[7])  irq_code = 5'd7;
    if (pending[3])  irq_code = 5'd3;
    if (pending[11]) irq_code = 5'd11;
  end

  assign take_irq   = mstatus_mie && (pending != '0);
  assign is_irq     = take_irq && !exception;
  assign trap       = exception || take_irq;
  assign cause_code = exception ? {1'b0, exception_cause} : irq_code;
  assign trap_pc    = {mtvec_q[31:2], 2'b00} +
                      ((mtvec_q[0] && is_irq) ? {25'b0, cause_code, 2'b00} : 32'h0);
  assign mepc_out   = mepc_q;

  // A trap or mret in the same cycle drops the CSR write completely.
  assign csr_commit = write_en && !trap && !mret;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_q        <= '0;
      mip_q        <= '0;
      mtvec_q      <= {RESET_VECTOR[31:2], 2'b00};
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
      mscratch_q   <= '0;
    end else begin
      mip_q <= irq_lines & IRQ_MASK;
      if (trap) begin
        mepc_q       <= {current_pc[31:2], 2'b00};
        mcause_q     <= {is_irq, 26'b0, cause_code};
        mtval_q      <= exception ? exception_tval : 32'h0;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end else if (csr_commit) begin
        case (number)
          12'h300: begin
            mstatus_mie  <= wval[3];
            mstatus_mpie <= wval[7];
          end
          12'h304: mie_q      <= wval & IRQ_MASK;
          12'h305: mtvec_q    <= {wval[31:2], 1'b0, VECTORED ? wval[0] : 1'b0};
          12'h340: mscratch_q <= wval;
          12'h341: mepc_q     <= {wval[31:2], 2'b00};
          12'h342: mcause_q   <= wval;
          12'h343: mtval_q    <= wval;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else if (HAS_COUNTERS) begin
      if (csr_commit && number == 12'hB00)      mcycle_q[31:0]  <= wval;
      else if (csr_commit && number == 12'hB80) mcycle_q[63:32] <= wval;
      else                                      mcycle_q        <= mcycle_q + 64'd1;

      if (csr_commit && number == 12'hB02)      minstret_q[31:0]  <= wval;
      else if (csr_commit && number == 12'hB82) minstret_q[63:32] <= wval;
      else if (instret && !trap)                minstret_q        <= minstret_q + 64'd1;
    end
  end

endmodule

// File: tb/tb_csr_machine.sv
// Bench for csr_machine: table of single-cycle CSR accesses plus hand-written trap/mret/counter sequences.
module tb_csr_machine;

  localparam logic [1:0] RD = 2'd0, WR = 2'd1, ST = 2'd2, CL = 2'd3;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csr_en;
  logic [11:0] number;
  logic [1:0]  access_type;
  logic [31:0] wdata, rdata;
  logic        illegal;
  logic        external_irq, timer_irq, software_irq;
  logic [3:0]  local_irq;
  logic        exception;
  logic [3:0]  exception_cause;
  logic [31:0] exception_tval, current_pc;
  logic        instret, mret, trap;
  logic [31:0] trap_pc, mepc_out;

  always #5 clk = ~clk;

  csr_machine #(.NUM_LOCAL_IRQ(4), .VECTORED(1'b1), .RESET_VECTOR(32'h0000_0203), .HAS_COUNTERS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .csr_en(csr_en), .number(number), .access_type(access_type),
    .wdata(wdata), .rdata(rdata), .illegal(illegal), .external_irq(external_irq),
    .timer_irq(timer_irq), .software_irq(software_irq), .local_irq(local_irq),
    .exception(exception), .exception_cause(exception_cause), .exception_tval(exception_tval),
    .current_pc(current_pc), .instret(instret), .mret(mret), .trap(trap), .trap_pc(trap_pc),
    .mepc_out(mepc_out)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    string       name;
    logic        en;
    logic [11:0] num;
    logic [1:0]  acc;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ill;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0:       return rdata;
      1:       return {31'b0, illegal};
      2:       return {31'b0, trap};
      3:       return trap_pc;
      default: return mepc_out;
    endcase
  endfunction

  task automatic expect_o(input string name, input int sel, input logic [31:0] exp);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic flush();
    exp_t e;
    logic [31:0] act;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      act = observe(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic peek(input logic [11:0] n, input logic [31:0] exp, input string name);
    number = n;
    expect_o(name, 0, exp);
    #1;
    flush();
  endtask

  task automatic tick();
    #1;
    flush();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_en = 1'b0; access_type = RD; wdata = '0;
    exception = 1'b0; mret = 1'b0; instret = 1'b0;
  endtask

  task automatic csr_op(input logic [11:0] n, input logic [1:0] a, input logic [31:0] w,
                        input logic [31:0] exp_r, input string name);
    csr_en = 1'b1; number = n; access_type = a; wdata = w;
    expect_o(name, 0, exp_r);
    expect_o({name, "_ill"}, 1, 32'h0);
    tick();
    idle();
  endtask

  initial begin
    reset_n = 1'b0; number = 12'h300;
    external_irq = 0; timer_irq = 0; software_irq = 0; local_irq = '0;
    exception_cause = '0; exception_tval = '0; current_pc = '0;
    idle();

    vt.push_back('{"misa",       1'b1, 12'h301, RD, 32'h0,         32'h4000_0100, 1'b0});
    vt.push_back('{"mstatus_rst",1'b1, 12'h300, RD, 32'h0,         32'h0000_1800, 1'b0});
    vt.push_back('{"mtvec_rst",  1'b1, 12'h305, RD, 32'h0,         32'h0000_0200, 1'b0});
    vt.push_back('{"mvendorid",  1'b1, 12'hF11, RD, 32'h0,         32'h0,         1'b0});
    vt.push_back('{"unimpl",     1'b1, 12'h7C0, RD, 32'h0,         32'h0,         1'b1});
    vt.push_back('{"noen",       1'b0, 12'h7C0, WR, 32'h0,         32'h0,         1'b0});
    vt.push_back('{"mhartid_wr", 1'b1, 12'hF14, WR, 32'h55,        32'h0,         1'b1});
    vt.push_back('{"mhartid_rd", 1'b1, 12'hF14, RD, 32'h0,         32'h0,         1'b0});
    vt.push_back('{"mscr_wr",    1'b1, 12'h340, WR, 32'hA5A5_0001, 32'h0,         1'b0});
    vt.push_back('{"mscr_set",   1'b1, 12'h340, ST, 32'h0F00_0000, 32'hA5A5_0001, 1'b0});
    vt.push_back('{"mscr_clr",   1'b1, 12'h340, CL, 32'h0000_0001, 32'hAFA5_0001, 1'b0});
    vt.push_back('{"mscr_rd",    1'b1, 12'h340, RD, 32'h0,         32'hAFA5_0000, 1'b0});
    vt.push_back('{"mepc_wr",    1'b1, 12'h341, WR, 32'h0000_1237, 32'h0,         1'b0});
    vt.push_back('{"mepc_rd",    1'b1, 12'h341, RD, 32'h0,         32'h0000_1234, 1'b0});
    vt.push_back('{"mtvec_wr1",  1'b1, 12'h305, WR, 32'hFFFF_FFFF, 32'h0000_0200, 1'b0});
    vt.push_back('{"mtvec_rd1",  1'b1, 12'h305, RD, 32'h0,         32'hFFFF_FFFD, 1'b0});
    vt.push_back('{"mtvec_wr2",  1'b1, 12'h305, WR, 32'h0000_1000, 32'hFFFF_FFFD, 1'b0});
    vt.push_back('{"mie_wr",     1'b1, 12'h304, WR, 32'hFFFF_FFFF, 32'h0,         1'b0});
    vt.push_back('{"mie_clr",    1'b1, 12'h304, CL, 32'hFFFF_FFFF, 32'h000F_0888, 1'b0});
    vt.push_back('{"mip_wr",     1'b1, 12'h344, WR, 32'h0000_FFFF, 32'h0,         1'b0});
    vt.push_back('{"mip_rd",     1'b1, 12'h344, RD, 32'h0,         32'h0,         1'b0});
    vt.push_back('{"mstat_wr",   1'b1, 12'h300, WR, 32'hFFFF_FFFF, 32'h0000_1800, 1'b0});
    vt.push_back('{"mstat_rd",   1'b1, 12'h300, RD, 32'h0,         32'h0000_1888, 1'b0});
    vt.push_back('{"mstat_wr0",  1'b1, 12'h300, WR, 32'h0,         32'h0000_1888, 1'b0});
    vt.push_back('{"misa_wr",    1'b1, 12'h301, WR, 32'h0,         32'h4000_0100, 1'b0});
    vt.push_back('{"misa_rd",    1'b1, 12'h301, RD, 32'h0,         32'h4000_0100, 1'b0});

    // Reset state, sampled while reset is still asserted
    #3;
    expect_o("rst_mstatus", 0, 32'h0000_1800);
    expect_o("rst_trap", 2, 32'h0);
    expect_o("rst_mepc_out", 4, 32'h0);
    flush();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    foreach (vt[i]) begin
      csr_en = vt[i].en; number = vt[i].num; access_type = vt[i].acc; wdata = vt[i].wd;
      expect_o(vt[i].name, 0, vt[i].rd);
      expect_o({vt[i].name, "_ill"}, 1, {31'b0, vt[i].ill});
      expect_o({vt[i].name, "_trap"}, 2, 32'h0);
      tick();
    end
    idle();

    // External interrupt: one cycle of mip latency, then trap and MIE/MPIE stacking
    csr_op(12'h304, ST, 32'h800, 32'h0, "t2_mie");
    csr_op(12'h300, ST, 32'h8, 32'h1800, "t2_mst");
    external_irq = 1; current_pc = 32'h80;
    expect_o("t2_nopend", 2, 0); tick();
    expect_o("t2_trap", 2, 1); expect_o("t2_pc", 3, 32'h1000); tick();
    external_irq = 0;
    expect_o("t2_masked", 2, 0); expect_o("t2_mepc_out", 4, 32'h80);
    peek(12'h342, 32'h8000_000B, "t2_mcause");
    peek(12'h300, 32'h0000_1880, "t2_mstatus");
    peek(12'h341, 32'h80, "t2_mepc");
    tick();

    mret = 1; expect_o("t5_mret_notrap", 2, 0); tick(); idle();
    expect_o("t5_mepc_out", 4, 32'h80);
    peek(12'h300, 32'h0000_1888, "t5_mstatus");
    tick();
    mret = 1; csr_en = 1; number = 12'h340; access_type = WR; wdata = 32'h1111;
    expect_o("t5_mscr_pre", 0, 32'hAFA5_0000); tick(); idle();
    peek(12'h340, 32'hAFA5_0000, "t5_mscr_dropped");
    tick();

    // Vectored mtvec with timer interrupt, then direct mode
    csr_op(12'h305, WR, 32'h1001, 32'h1000, "t3_mtvec");
    csr_op(12'h304, WR, 32'h80, 32'h800, "t3_mie");
    timer_irq = 1; current_pc = 32'h200;
    expect_o("t3_nopend", 2, 0); tick();
    expect_o("t3_trap", 2, 1); expect_o("t3_vec_pc", 3, 32'h101C); tick();
    timer_irq = 0;
    csr_en = 1; number = 12'h305; access_type = WR; wdata = 32'h1000;
    expect_o("t3_mtvec2_pre", 0, 32'h1001); expect_o("t3_masked", 2, 0); tick(); idle();
    peek(12'h342, 32'h8000_0007, "t3_mcause");
    mret = 1; expect_o("t3_mret", 2, 0); tick(); idle();
    timer_irq = 1; expect_o("t3_nopend2", 2, 0); tick();
    expect_o("t3_trap2", 2, 1); expect_o("t3_direct_pc", 3, 32'h1000); tick();
    timer_irq = 0;

    // Local interrupt with vectored offset 4*17
    csr_op(12'h305, WR, 32'h2001, 32'h1000, "loc_mtvec");
    csr_op(12'h304, WR, 32'hFFFF_FFFF, 32'h80, "loc_mie");
    mret = 1; tick(); idle();
    local_irq = 4'b0110; expect_o("loc_nopend", 2, 0); tick();
    expect_o("loc_trap", 2, 1); expect_o("loc_pc", 3, 32'h2044); tick();
    local_irq = '0;
    peek(12'h342, 32'h8000_0011, "loc_mcause");
    expect_o("loc_masked", 2, 0); tick();

    // Exception beats mret and CSR write in the same cycle
    exception = 1; exception_cause = 4'd2; exception_tval = 32'hDEAD; current_pc = 32'h40;
    mret = 1; csr_en = 1; number = 12'h340; access_type = WR; wdata = 32'h5555;
    expect_o("t4_trap", 2, 1); expect_o("t4_pc", 3, 32'h2000); expect_o("t4_mscr_pre", 0, 32'hAFA5_0000);
    tick(); idle();
    expect_o("t4_mepc_out", 4, 32'h40);
    peek(12'h341, 32'h40, "t4_mepc");
    peek(12'h342, 32'h2, "t4_mcause");
    peek(12'h343, 32'hDEAD, "t4_mtval");
    peek(12'h340, 32'hAFA5_0000, "t4_mscratch");
    peek(12'h300, 32'h0000_1800, "t4_mstatus");
    tick();

    // MSI outranks MTI and local lines
    csr_op(12'h300, ST, 32'h8, 32'h1800, "pri_mst");
    software_irq = 1; timer_irq = 1; local_irq = 4'b0001;
    expect_o("pri_nopend", 2, 0); tick();
    expect_o("pri_trap", 2, 1); expect_o("pri_pc", 3, 32'h200C); tick();
    software_irq = 0; timer_irq = 0; local_irq = '0;
    peek(12'h342, 32'h8000_0003, "pri_mcause");
    tick();

    // minstret: write suppresses the increment, trap suppresses retirement
    instret = 1; csr_en = 1; number = 12'hB02; access_type = WR; wdata = 32'h5;
    expect_o("ir_pre", 0, 32'h0); tick(); idle();
    instret = 1; peek(12'hB02, 32'h5, "ir_after_wr"); tick();
    instret = 1; exception = 1; peek(12'hB02, 32'h6, "ir_inc"); tick(); idle();
    peek(12'hB02, 32'h6, "ir_trap_hold");
    peek(12'hB82, 32'h0, "ir_hi");
    tick();

    // mcycle carry into the high half
    csr_en = 1; number = 12'hB00; access_type = WR; wdata = 32'hFFFF_FFFF;
    expect_o("mc_lo_ill", 1, 0); tick();
    number = 12'hB80; wdata = 32'h0; tick(); idle();
    peek(12'hB80, 32'h0, "mc_hi0");
    peek(12'hB00, 32'hFFFF_FFFF, "mc_lo_hold");
    tick();
    peek(12'hB80, 32'h1, "mc_hi1");
    peek(12'hB00, 32'h0, "mc_lo0");
    tick();

    // Asynchronous reset mid-count
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    peek(12'hB00, 32'h0, "rst2_mcycle");
    peek(12'hB80, 32'h0, "rst2_mcycleh");
    peek(12'hB02, 32'h0, "rst2_minstret");
    peek(12'h305, 32'h200, "rst2_mtvec");
    expect_o("rst2_mepc_out", 4, 32'h0);
    flush();
    @(posedge clk);
    #1 reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
